change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser.sv | 164 ++++++++++++++++
 tb/tb_change_dispenser.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Greedy coin-change dispenser: breaks an amount into coins and hands them out one per ack.
// Build option: define DOLLAR_COIN_EN to let the greedy selection use the dollar coin.
module change_dispenser (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [8:0] amount,
  input  logic       coin_ack,
  output logic       coin_valid,
  output logic [1:0] coin_type,
  output logic       busy,
  output logic       done,
  output logic       rem_err,
  output logic       range_err,
  output logic [4:0] coins_out
);

  localparam int unsigned AMT_W      = 9;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned TYPE_W     = 2;
  localparam int unsigned AMOUNT_MAX = 500;

  localparam logic [TYPE_W-1:0] COIN_NICKEL  = 2'b00;
  localparam logic [TYPE_W-1:0] COIN_DIME    = 2'b01;
  localparam logic [TYPE_W-1:0] COIN_QUARTER = 2'b10;
  localparam logic [TYPE_W-1:0] COIN_DOLLAR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    EMIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [AMT_W-1:0]   remaining_q, remaining_d;
  logic [CNT_W-1:0]   coins_q, coins_d;
  logic [TYPE_W-1:0]  coin_type_q, coin_type_d;
  logic               coin_valid_q, coin_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rem_err_q, rem_err_d;
  logic               range_err_q, range_err_d;

  // Face value in cents of a coin code.
  function automatic logic [AMT_W-1:0] coin_value(input logic [TYPE_W-1:0] t);
    logic [AMT_W-1:0] v;
    unique case (t)
      COIN_NICKEL:  v = AMT_W'(5);
      COIN_DIME:    v = AMT_W'(10);
      COIN_QUARTER: v = AMT_W'(25);
      default:      v = AMT_W'(100);
    endcase
    return v;
  endfunction

  // Largest enabled coin not exceeding rem; caller guarantees rem >= 5.
  function automatic logic [TYPE_W-1:0] pick_coin(input logic [AMT_W-1:0] rem);
    logic [TYPE_W-1:0] t;
    t = COIN_NICKEL;
    if (rem >= AMT_W'(10)) t = COIN_DIME;
    if (rem >= AMT_W'(25)) t = COIN_QUARTER;
`ifdef DOLLAR_COIN_EN
    if (rem >= AMT_W'(100)) t = COIN_DOLLAR;
`endif
    return t;
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    coins_d      = coins_q;
    coin_type_d  = coin_type_q;
    coin_valid_d = coin_valid_q;
    busy_d       = busy_q;
    rem_err_d    = rem_err_q;
    done_d       = 1'b0;
    range_err_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (amount > AMT_W'(AMOUNT_MAX)) begin
            range_err_d = 1'b1;
          end else begin
            remaining_d = amount;
            coins_d     = '0;
            rem_err_d   = 1'b0;
            busy_d      = 1'b1;
            state_d     = SELECT;
          end
        end
      end

      SELECT: begin
        if (remaining_q >= AMT_W'(5)) begin
          coin_type_d  = pick_coin(remaining_q);
          coin_valid_d = 1'b1;
          state_d      = EMIT;
        end else begin
          rem_err_d = (remaining_q != '0);
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = DONE;
        end
      end

      EMIT: begin
        // Coin is held on the outputs until the mechanism takes it.
        if (coin_ack) begin
          remaining_d  = remaining_q - coin_value(coin_type_q);
          coin_valid_d = 1'b0;
          if (coins_q != {CNT_W{1'b1}}) begin
            coins_d = coins_q + CNT_W'(1);
          end
          state_d = SELECT;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      coins_q      <= '0;
      coin_type_q  <= '0;
      coin_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rem_err_q    <= 1'b0;
      range_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      coins_q      <= coins_d;
      coin_type_q  <= coin_type_d;
      coin_valid_q <= coin_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rem_err_q    <= rem_err_d;
      range_err_q  <= range_err_d;
    end
  end

  assign coin_valid = coin_valid_q;
  assign coin_type  = coin_type_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign rem_err    = rem_err_q;
  assign range_err  = range_err_q;
  assign coins_out  = coins_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: transaction-level greedy model, per-cycle compare, directed and random runs.
// Define DOLLAR_COIN_EN for both bench and design to exercise the dollar-coin build.
module tb_change_dispenser;

`ifdef DOLLAR_COIN_EN
  localparam bit DOLLAR = 1'b1;
`else
  localparam bit DOLLAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [8:0] amount = '0;
  logic       coin_ack = 1'b0;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       busy;
  logic       done;
  logic       rem_err;
  logic       range_err;
  logic [4:0] coins_out;

  change_dispenser dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .amount     (amount),
    .coin_ack   (coin_ack),
    .coin_valid (coin_valid),
    .coin_type  (coin_type),
    .busy       (busy),
    .done       (done),
    .rem_err    (rem_err),
    .range_err  (range_err),
    .coins_out  (coins_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;
  bit ack_random = 1'b0;
  int vcnt = 0;
  logic [1:0] coin_log[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Greedy breakdown by plain division: dollars (if enabled), quarters, dimes, nickels.
  function automatic int cnt_of(input int a);
    int nd, r;
    nd = DOLLAR ? a / 100 : 0;
    r  = a - nd * 100;
    return nd + r / 25 + (r % 25) / 10 + ((r % 25) % 10) / 5;
  endfunction

  function automatic logic [63:0] seq_of(input int a);
    logic [63:0] s;
    int nd, nq, ndm, nn, r, k;
    s   = '0;
    k   = 0;
    nd  = DOLLAR ? a / 100 : 0;
    r   = a - nd * 100;
    nq  = r / 25;  r = r % 25;
    ndm = r / 10;  r = r % 10;
    nn  = r / 5;
    for (int i = 0; i < nd;  i++) begin s[2*k +: 2] = 2'd3; k++; end
    for (int i = 0; i < nq;  i++) begin s[2*k +: 2] = 2'd2; k++; end
    for (int i = 0; i < ndm; i++) begin s[2*k +: 2] = 2'd1; k++; end
    for (int i = 0; i < nn;  i++) begin s[2*k +: 2] = 2'd0; k++; end
    return s;
  endfunction

  // Reference model: 0 idle, 1 between coins, 2 coin presented, 3 finishing.
  int          m_ph, m_idx, m_n, m_resid, m_coins;
  logic [63:0] m_seq;
  logic        m_busy, m_valid, m_done, m_rem_err, m_range;
  logic [1:0]  m_type;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= 0; m_idx <= 0; m_n <= 0; m_resid <= 0; m_coins <= 0; m_seq <= '0;
      m_busy <= 0; m_valid <= 0; m_done <= 0; m_rem_err <= 0; m_range <= 0; m_type <= 0;
    end else begin
      m_done  <= 1'b0;
      m_range <= 1'b0;
      case (m_ph)
        0: if (start) begin
          if (amount > 9'd500) begin
            m_range <= 1'b1;
          end else begin
            m_seq     <= seq_of(int'(amount));
            m_n       <= cnt_of(int'(amount));
            m_resid   <= int'(amount) % 5;
            m_idx     <= 0;
            m_coins   <= 0;
            m_rem_err <= 1'b0;
            m_busy    <= 1'b1;
            m_ph      <= 1;
          end
        end
        1: if (m_idx < m_n) begin
          m_valid <= 1'b1;
          m_type  <= m_seq[2*m_idx +: 2];
          m_ph    <= 2;
        end else begin
          m_done    <= 1'b1;
          m_busy    <= 1'b0;
          m_rem_err <= (m_resid != 0);
          m_ph      <= 3;
        end
        2: if (coin_ack) begin
          m_valid <= 1'b0;
          m_idx   <= m_idx + 1;
          m_coins <= (m_coins < 31) ? m_coins + 1 : 31;
          m_ph    <= 1;
        end
        default: m_ph <= 0;
      endcase
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("coin_valid", int'(coin_valid), int'(m_valid));
      check("busy", int'(busy), int'(m_busy));
      check("done", int'(done), int'(m_done));
      check("rem_err", int'(rem_err), int'(m_rem_err));
      check("range_err", int'(range_err), int'(m_range));
      check("coins_out", int'(coins_out), m_coins);
      if (m_valid) check("coin_type", int'(coin_type), int'(m_type));
      if (!DOLLAR && coin_valid) check("no_dollar_code", int'(coin_type == 2'b11), 0);
    end
  end

  // Coins actually taken by the mechanism.
  always @(posedge clk) begin
    if (rst_n && coin_valid && coin_ack) coin_log.push_back(coin_type);
  end

  // Ack driver: directed mode acks on the second cycle of a coin; random mode toggles freely.
  always @(negedge clk) begin
    if (ack_random) begin
      coin_ack = ($urandom_range(0, 2) == 0);
    end else if (coin_valid) begin
      vcnt++;
      coin_ack = (vcnt >= 2);
    end else begin
      vcnt = 0;
      coin_ack = 1'b0;
    end
  end

  task automatic start_txn(input int amt);
    @(negedge clk);
    start  = 1'b1;
    amount = 9'(amt);
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int got;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin got = 1; break; end
      @(negedge clk);
    end
    check("done_within_budget", got, 1);
  endtask

  task automatic check_log(input string name, input int exp_n, input logic [63:0] exp_seq);
    logic [63:0] s;
    s = exp_seq;
    check({name, "_count"}, coin_log.size(), exp_n);
    for (int i = 0; i < exp_n && i < coin_log.size(); i++)
      check({name, "_coin"}, int'(coin_log[i]), int'(s[2*i +: 2]));
  endtask

  task automatic run_directed(input int amt, input int exp_n, input logic [63:0] exp_seq,
                              input int exp_rem);
    coin_log.delete();
    start_txn(amt);
    wait_done(400);
    check("dir_coins_out", int'(coins_out), exp_n);
    check("dir_rem_err", int'(rem_err), exp_rem);
    check("dir_busy_at_done", int'(busy), 0);
    check_log("dir_seq", exp_n, exp_seq);
    @(negedge clk);
    check("dir_done_one_cycle", int'(done), 0);
  endtask

  initial begin
    int amt, ok;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_coin_valid", int'(coin_valid), 0);
    check("rst_coin_type", int'(coin_type), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_errs", int'({rem_err, range_err}), 0);
    check("rst_coins_out", int'(coins_out), 0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // 90: Q,Q,Q,D,N with foreign starts injected while busy.
    coin_log.delete();
    start_txn(90);
    repeat (2) @(negedge clk);
    start = 1'b1; amount = 9'd501;
    @(negedge clk);
    start = 1'b0;
    check("busy_range_ignored", int'(range_err), 0);
    start = 1'b1; amount = 9'd40;
    @(negedge clk);
    start = 1'b0;
    wait_done(400);
    check("t90_coins_out", int'(coins_out), 5);
    check("t90_rem_err", int'(rem_err), 0);
    check_log("t90_seq", 5, 64'h6A);
    repeat (3) @(negedge clk);
    check("t90_coins_hold", int'(coins_out), 5);

`ifdef DOLLAR_COIN_EN
    run_directed(371, 7, 64'h16BF, 1);
    run_directed(500, 5, 64'h3FF, 0);
`else
    run_directed(371, 16, 64'h5AAAAAAA, 1);
    run_directed(500, 20, 64'hAA_AAAA_AAAA, 0);
`endif

    // 501: range error pulse only.
    start_txn(501);
    check("t501_range_err", int'(range_err), 1);
    check("t501_busy", int'(busy), 0);
    check("t501_valid", int'(coin_valid), 0);
    check("t501_coins_hold", int'(coins_out), DOLLAR ? 5 : 20);
    @(negedge clk);
    check("t501_range_pulse", int'(range_err), 0);

    // 0: done two cycles after start, no coins.
    start_txn(0);
    check("t0_busy", int'(busy), 1);
    @(negedge clk);
    check("t0_done", int'(done), 1);
    check("t0_coins", int'(coins_out), 0);
    check("t0_rem_err", int'(rem_err), 0);

    // 125: reset while second coin is presented, then 25 gives one quarter.
    coin_log.delete();
    start_txn(125);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (coin_valid && coin_log.size() == 1) begin ok = 1; break; end
    end
    check("t125_second_coin", ok, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_coin_valid", int'(coin_valid), 0);
    check("arst_coin_type", int'(coin_type), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_coins_out", int'(coins_out), 0);
    check("arst_flags", int'({done, rem_err, range_err}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_directed(25, 1, 64'h2, 0);

    // Randomized transactions, random ack timing, stray starts while busy.
    ack_random = 1'b1;
    for (int t = 0; t < 40; t++) begin
      amt = $urandom_range(0, 520);
      if (t == 0) amt = 500;
      start_txn(amt);
      if (amt <= 500) begin
        if ($urandom_range(0, 3) == 0) begin
          start = 1'b1; amount = 9'($urandom_range(0, 511));
          @(negedge clk);
          start = 1'b0;
        end
        wait_done(1500);
      end
      @(negedge clk);
    end
    ack_random = 1'b0;
    repeat (3) @(negedge clk);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d failures=%0d)", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
